// File: rtl/hcf_pkg.sv
// Shared types for the HCF engine share controller.
// Holds the FSM state enum, default width and id-width helper.
package hcf_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT,
      RESP
   } state_t;

   localparam int HCF_W = 4;

   // Index width for n requesters, never below one bit.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hcf_rr_pick.sv
// Combinational round-robin picker.
// Ports: req (pending vector), last (previous grant index),
//        grant (one-hot), idx (grant index), any (some req set).
module hcf_rr_pick
   import hcf_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = id_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   int             kk;
   logic [IDW-1:0] k;

   // Search starts one past the last winner and wraps, so
   // the last winner itself is checked last.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      kk    = 0;
      k     = '0;
      for (int i = 1; i <= NREQ; i++) begin
         kk = int'(last) + i;
         if (kk >= NREQ) kk = kk - NREQ;
         k = IDW'(kk);
         if (!any && req[k]) begin
            any      = 1'b1;
            grant[k] = 1'b1;
            idx      = k;
         end
      end
   end

endmodule

// File: rtl/hcf_share_ctrl.sv
// Shares one HCF (GCD) engine among NREQ requesters, round-robin.
// Ports: clk/clear (sync reset), req_valid/ready/a/b (clients),
//        rsp_valid/ready/id/hcf/err (result), eng_* (engine), busy.
// Option: HCF_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT cycles
//         that pulses eng_clear and returns rsp_err=1, rsp_hcf=0.
module hcf_share_ctrl
   import hcf_pkg::*;
#(
   parameter  int NREQ    = 4,
   parameter  int W       = HCF_W,
   parameter  int TIMEOUT = 64,
   localparam int IDW     = id_w(NREQ)
) (
   input  logic              clk,
   input  logic              clear,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_hcf,
   output logic              rsp_err,
   output logic [W-1:0]      eng_a,
   output logic [W-1:0]      eng_b,
   output logic              eng_start,
   input  logic              eng_done,
   input  logic [W-1:0]      eng_hcf,
   output logic              eng_clear,
   output logic              busy
);

   state_t          state, nstate;
   logic [IDW-1:0]  last_grant;
   logic [W-1:0]    a_q, b_q, hcf_q;
   logic [IDW-1:0]  id_q;
   logic [NREQ-1:0] pgrant;
   logic [IDW-1:0]  pidx;
   logic            pany;
   logic            tmo;

   hcf_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req   (req_valid),
      .last  (last_grant),
      .grant (pgrant),
      .idx   (pidx),
      .any   (pany)
   );

`ifdef HCF_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wcnt;
   logic          err_q;

   // Fires on the TIMEOUT-th WAIT cycle without a done.
   assign tmo = (state == WAIT) && !eng_done &&
                (wcnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (clear || state != WAIT) wcnt <= '0;
      else                        wcnt <= wcnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (clear)                         err_q <= 1'b0;
      else if (state == WAIT && eng_done) err_q <= 1'b0;
      else if (tmo)                      err_q <= 1'b1;
   end

   assign rsp_err = err_q;
`else
   assign tmo     = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (clear) begin
         state      <= IDLE;
         last_grant <= IDW'(NREQ - 1);
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= '0;
         hcf_q      <= '0;
      end else begin
         state <= nstate;
         case (state)
            IDLE: if (pany) begin
               a_q  <= req_a[int'(pidx)*W +: W];
               b_q  <= req_b[int'(pidx)*W +: W];
               id_q <= pidx;
            end
            WAIT: begin
               if (eng_done)  hcf_q <= eng_hcf;
               else if (tmo)  hcf_q <= '0;
            end
            RESP: if (rsp_ready) last_grant <= id_q;
            default: ;
         endcase
      end
   end

   always_comb begin
      nstate    = state;
      req_ready = '0;
      eng_start = 1'b0;
      eng_clear = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = pgrant;
            if (pany) nstate = LOAD;
         end
         LOAD: begin
            eng_start = 1'b1;
            nstate    = WAIT;
         end
         WAIT: begin
            if (eng_done) begin
               nstate = RESP;
            end else if (tmo) begin
               eng_clear = 1'b1;
               nstate    = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

   assign eng_a   = a_q;
   assign eng_b   = b_q;
   assign rsp_id  = id_q;
   assign rsp_hcf = hcf_q;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_hcf_share_ctrl.sv
// Scoreboard bench for hcf_share_ctrl with a delayed engine model.
// Grants and responses are checked against queued expectations.
module tb_hcf_share_ctrl;

   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int TMO  = 16;

   logic              clk = 1'b0;
   logic              clear;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a, req_b;
   logic              rsp_valid, rsp_ready;
   logic [1:0]        rsp_id;
   logic [W-1:0]      rsp_hcf;
   logic              rsp_err;
   logic [W-1:0]      eng_a, eng_b, eng_hcf;
   logic              eng_start, eng_done, eng_clear, busy;

   typedef struct packed {
      logic [1:0]   id;
      logic [W-1:0] hcf;
      logic         err;
   } rsp_t;

   rsp_t       exp_rsp[$];
   logic [1:0] exp_gnt[$];
   rsp_t       er;
   logic [1:0] eg;

   int total = 0;
   int bad   = 0;
   int n_gnt = 0;
   int n_rsp = 0;
   int cyc   = 0;
   int dly   = 1;

   int         want[NREQ];
   int         got[NREQ];
   logic [W-1:0] opa[NREQ];
   logic [W-1:0] opb[NREQ];

   logic         e_act = 1'b0;
   int           e_cnt = 0;
   logic [W-1:0] e_res = '0;

   always #5 clk = ~clk;

   hcf_share_ctrl #(
      .NREQ    (NREQ),
      .W       (W),
      .TIMEOUT (TMO)
   ) dut (
      .clk       (clk),
      .clear     (clear),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_hcf   (rsp_hcf),
      .rsp_err   (rsp_err),
      .eng_a     (eng_a),
      .eng_b     (eng_b),
      .eng_start (eng_start),
      .eng_done  (eng_done),
      .eng_hcf   (eng_hcf),
      .eng_clear (eng_clear),
      .busy      (busy)
   );

   function automatic logic [W-1:0] gcd(input logic [W-1:0] a,
                                        input logic [W-1:0] b);
      logic [W-1:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Requester i is pending while it has issued more than was granted.
   always_comb begin
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]     = (want[i] > got[i]);
         req_a[i*W +: W] = opa[i];
         req_b[i*W +: W] = opb[i];
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < NREQ; i++)
         if (req_valid[i] && req_ready[i]) got[i] <= got[i] + 1;
   end

   // Engine model: done dly cycles after start; dly=0 never finishes.
   always @(posedge clk) begin
      if (eng_clear) begin
         e_act <= 1'b0;
      end else if (eng_start) begin
         e_act <= 1'b1;
         e_cnt <= 1;
         e_res <= gcd(eng_a, eng_b);
      end else if (e_act) begin
         if (eng_done) e_act <= 1'b0;
         else          e_cnt <= e_cnt + 1;
      end
   end

   assign eng_done = e_act && (dly != 0) && (e_cnt == dly);
   assign eng_hcf  = e_res;

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (|(req_valid & req_ready)) begin
         n_gnt++;
         total++;
         if (exp_gnt.size() == 0) begin
            bad++;
            $display("FAIL grant_unexpected got=%b want=none", req_ready);
         end else begin
            eg = exp_gnt.pop_front();
            if (req_ready !== (4'b0001 << eg)) begin
               bad++;
               $display("FAIL grant_order got=%b want=%b",
                        req_ready, 4'b0001 << eg);
            end
         end
      end
      if (rsp_valid && rsp_ready) begin
         n_rsp++;
         total++;
         if (exp_rsp.size() == 0) begin
            bad++;
            $display("FAIL rsp_unexpected got id=%0d hcf=%0d err=%0d",
                     rsp_id, rsp_hcf, rsp_err);
         end else begin
            er = exp_rsp.pop_front();
            if ({rsp_id, rsp_hcf, rsp_err} !== er) begin
               bad++;
               $display("FAIL rsp got id=%0d hcf=%0d err=%0d want id=%0d hcf=%0d err=%0d",
                        rsp_id, rsp_hcf, rsp_err, er.id, er.hcf, er.err);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick(2);
      clear = 1'b0;
   endtask

   task automatic push(input int id, input int a, input int b);
      opa[id] = W'(a);
      opb[id] = W'(b);
      exp_gnt.push_back(2'(id));
      exp_rsp.push_back({2'(id), gcd(W'(a), W'(b)), 1'b0});
   endtask

   task automatic wait_rsp(input int target, input int budget,
                           input string name);
      int b;
      b = 0;
      while (n_rsp < target && b < budget) begin
         @(negedge clk);
         b++;
      end
      total++;
      if (n_rsp < target) begin
         bad++;
         $display("FAIL %s_timeout got=%0d want=%0d", name, n_rsp, target);
      end
      tick(1);
   endtask

   task automatic wait_start(output int c, output bit ok);
      int b;
      b  = 0;
      ok = 1'b0;
      c  = 0;
      while (!ok && b < 50) begin
         @(negedge clk);
         b++;
         if (eng_start) begin
            ok = 1'b1;
            c  = cyc;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL start_timeout got=0 want=1");
      end
   endtask

   task automatic test_reset();
      clear     = 1'b1;
      rsp_ready = 1'b1;
      tick(2);
      @(negedge clk);
      total++;
      if ({req_ready, rsp_valid, rsp_id, rsp_hcf, rsp_err, eng_a, eng_b,
           eng_start, eng_clear, busy} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got rr=%b rv=%b busy=%b ea=%0d want 0",
                  req_ready, rsp_valid, busy, eng_a);
      end
      tick(1);
      clear = 1'b0;
   endtask

   task automatic test_single();
      int g0, t, c0, c1, b;
      dly = 3;
      g0  = n_gnt;
      t   = n_rsp;
      c0  = -1;
      c1  = -1;
      push(0, 8, 12);
      want[0]++;
      b = 0;
      while (c1 < 0 && b < 40) begin
         @(negedge clk);
         b++;
         if (c0 < 0 && req_ready[0]) c0 = cyc;
         if (c1 < 0 && rsp_valid)    c1 = cyc;
      end
      total++;
      if (c1 - c0 != 5 || c0 < 0) begin
         bad++;
         $display("FAIL single_latency got=%0d want=5", c1 - c0);
      end
      wait_rsp(t + 1, 20, "single");
      tick(3);
      total++;
      if (n_gnt - g0 !== 1) begin
         bad++;
         $display("FAIL single_pulses got=%0d want=1", n_gnt - g0);
      end
   endtask

   task automatic test_two();
      int t;
      do_clear();
      dly = 2;
      t   = n_rsp;
      push(0, 8, 12);
      push(2, 9, 6);
      want[0]++;
      want[2]++;
      wait_rsp(t + 2, 60, "two");
   endtask

   task automatic test_back_to_back();
      int t, g, b;
      do_clear();
      dly = 1;
      t   = n_rsp;
      g   = n_gnt;
      push(0, 8, 12);
      push(1, 15, 10);
      push(2, 9, 6);
      push(3, 7, 14);
      push(0, 8, 12);
      for (int i = 0; i < NREQ; i++) want[i] += 2;
      b = 0;
      while (n_gnt < g + 5 && b < 80) begin
         @(negedge clk);
         b++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) want[i] = got[i];
      wait_rsp(t + 5, 60, "b2b");
   endtask

   task automatic test_stall();
      int t, b;
      dly       = 2;
      t         = n_rsp;
      rsp_ready = 1'b0;
      push(1, 15, 10);
      want[1]++;
      b = 0;
      while (!rsp_valid && b < 30) begin
         @(negedge clk);
         b++;
      end
      @(posedge clk);
      #1;
      push(3, 7, 14);
      want[3]++;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if ({rsp_valid, rsp_id, rsp_hcf, rsp_err, req_ready, busy} !==
             {1'b1, 2'd1, 4'd5, 1'b0, 4'b0000, 1'b1}) begin
            bad++;
            $display("FAIL stall_hold got v=%b id=%0d hcf=%0d rr=%b busy=%b want v=1 id=1 hcf=5 rr=0000 busy=1",
                     rsp_valid, rsp_id, rsp_hcf, req_ready, busy);
         end
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      wait_rsp(t + 2, 40, "stall");
   endtask

   task automatic test_latency();
      int t, c0, c1, b;
      dly = 1;
      t   = n_rsp;
      c0  = -1;
      c1  = -1;
      push(2, 12, 8);
      want[2]++;
      b = 0;
      while (c1 < 0 && b < 30) begin
         @(negedge clk);
         b++;
         if (c0 < 0 && req_ready[2]) c0 = cyc;
         if (c1 < 0 && rsp_valid)    c1 = cyc;
      end
      total++;
      if (c1 - c0 != 3 || c0 < 0) begin
         bad++;
         $display("FAIL min_latency got=%0d want=3", c1 - c0);
      end
      wait_rsp(t + 1, 20, "latency");
   endtask

   task automatic test_clear_mid();
      int c, n0, viol;
      bit ok;
      dly = 6;
      n0  = n_rsp;
      opa[2] = 4'd9;
      opb[2] = 4'd6;
      exp_gnt.push_back(2'd2);
      want[2]++;
      wait_start(c, ok);
      tick(2);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      @(negedge clk);
      total++;
      if ({req_ready, rsp_valid, rsp_id, rsp_hcf, rsp_err, eng_a, eng_b,
           eng_start, eng_clear, busy} !== '0) begin
         bad++;
         $display("FAIL clear_outputs got rv=%b busy=%b ea=%0d eb=%0d want 0",
                  rsp_valid, busy, eng_a, eng_b);
      end
      viol = 0;
      repeat (12) begin
         @(negedge clk);
         if (rsp_valid || busy) viol++;
      end
      total++;
      if (viol != 0 || n_rsp != n0) begin
         bad++;
         $display("FAIL clear_late_done got viol=%0d rsp=%0d want 0 %0d",
                  viol, n_rsp, n0);
      end
      tick(1);
   endtask

   task automatic test_timeout();
      int cs, t, viol;
      bit ok;
      dly = 0;
      t   = n_rsp;
      opa[0] = 4'd8;
      opb[0] = 4'd12;
      exp_gnt.push_back(2'd0);
`ifdef HCF_TIMEOUT_EN
      exp_rsp.push_back({2'd0, 4'd0, 1'b1});
`endif
      want[0]++;
      wait_start(cs, ok);
`ifdef HCF_TIMEOUT_EN
      begin
         int cc, cr, np;
         cc = -1;
         cr = -1;
         np = 0;
         repeat (40) begin
            @(negedge clk);
            if (eng_clear) begin
               np++;
               if (cc < 0) cc = cyc;
            end
            if (rsp_valid && cr < 0) cr = cyc;
         end
         total++;
         if (cc - cs != TMO || np != 1 || cr != cc + 1) begin
            bad++;
            $display("FAIL timeout_abort got clr=%0d n=%0d rsp=%0d want %0d 1 %0d",
                     cc - cs, np, cr - cs, TMO, TMO + 1);
         end
         wait_rsp(t + 1, 10, "timeout");
      end
`else
      viol = 0;
      repeat (40) begin
         @(negedge clk);
         if (!busy || rsp_valid || eng_clear) viol++;
      end
      total++;
      if (viol != 0 || n_rsp != t) begin
         bad++;
         $display("FAIL hang_busy got viol=%0d want 0", viol);
      end
      do_clear();
`endif
   endtask

   initial begin
      clear     = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         want[i] = 0;
         got[i]  = 0;
         opa[i]  = '0;
         opb[i]  = '0;
      end
      test_reset();
      test_single();
      test_two();
      test_back_to_back();
      test_stall();
      test_latency();
      test_clear_mid();
      test_timeout();
      tick(2);
      total++;
      if (exp_gnt.size() != 0 || exp_rsp.size() != 0) begin
         bad++;
         $display("FAIL leftover got gnt=%0d rsp=%0d want 0 0",
                  exp_gnt.size(), exp_rsp.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
